// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC and keeps one request outstanding on the instruction bus.
// It hands each fetched word to decode with a single-cycle strobe and drops fetches made stale by a redirect.
module ifu_fetch #(
    parameter logic [63:0] PC_RESET  = 64'h0000_0000_8000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    input  logic        stall,
    output logic        ibus_req,
    output logic [63:0] ibus_addr,
    input  logic        ibus_ready,
    input  logic        ibus_rvalid,
    input  logic [31:0] ibus_rdata,
    output logic [31:0] instr,
    output logic [63:0] instr_pc,
    output logic        idu_valid,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DELIVER,
        S_HALT
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [63:0] pc;
    logic [63:0] pc_nxt;
    logic [63:0] pend_pc;
    logic [63:0] pend_nxt;
    logic        kill;
    logic        kill_nxt;
    logic        err;
    logic        err_nxt;
    logic        vld_nxt;
    logic        ferr_nxt;
    logic [31:0] instr_nxt;
    logic [63:0] instr_pc_nxt;
    logic        misaligned;

    assign misaligned = (pc[1:0] != 2'b00);

    // A misaligned PC never reaches the bus; the REQ cycle is spent routing it to error delivery.
    assign ibus_req  = (state == S_REQ) && !misaligned;
    assign ibus_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            pc        <= PC_RESET;
            kill      <= 1'b0;
            err       <= 1'b0;
            idu_valid <= 1'b0;
            fetch_err <= 1'b0;
            instr     <= NOP_INSTR;
            instr_pc  <= PC_RESET;
        end else begin
            state     <= state_nxt;
            pc        <= pc_nxt;
            kill      <= kill_nxt;
            err       <= err_nxt;
            idu_valid <= vld_nxt;
            fetch_err <= ferr_nxt;
            instr     <= instr_nxt;
            instr_pc  <= instr_pc_nxt;
        end
    end

    // Redirect target parked while a killed fetch drains; only meaningful when kill is set.
    always_ff @(posedge clk) begin
        pend_pc <= pend_nxt;
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        pend_nxt     = pend_pc;
        kill_nxt     = kill;
        err_nxt      = err;
        vld_nxt      = 1'b0;
        ferr_nxt     = 1'b0;
        instr_nxt    = instr;
        instr_pc_nxt = instr_pc;

        case (state)
            S_IDLE: begin
                if (redirect) begin
                    pc_nxt = redirect_pc;
                end
                state_nxt = S_REQ;
            end

            S_REQ: begin
                if (misaligned) begin
                    if (redirect) begin
                        pc_nxt = redirect_pc;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = S_DELIVER;
                    end
                end else begin
                    // Address must hold until accepted, so a redirect here only arms the kill.
                    if (redirect) begin
                        kill_nxt = 1'b1;
                        pend_nxt = redirect_pc;
                    end
                    if (ibus_ready) begin
                        state_nxt = S_WAIT;
                    end
                end
            end

            S_WAIT: begin
                if (redirect && ibus_rvalid) begin
                    kill_nxt  = 1'b0;
                    pc_nxt    = redirect_pc;
                    state_nxt = S_REQ;
                end else if (redirect) begin
                    kill_nxt = 1'b1;
                    pend_nxt = redirect_pc;
                end else if (ibus_rvalid) begin
                    if (kill) begin
                        kill_nxt  = 1'b0;
                        pc_nxt    = pend_pc;
                        state_nxt = S_REQ;
                    end else begin
                        instr_nxt    = ibus_rdata;
                        instr_pc_nxt = pc;
                        state_nxt    = S_DELIVER;
                    end
                end
            end

            S_DELIVER: begin
                if (redirect) begin
                    err_nxt   = 1'b0;
                    pc_nxt    = redirect_pc;
                    state_nxt = S_REQ;
                end else if (!stall) begin
                    vld_nxt = 1'b1;
                    if (err) begin
                        ferr_nxt     = 1'b1;
                        instr_nxt    = NOP_INSTR;
                        instr_pc_nxt = pc;
                        state_nxt    = S_HALT;
                    end else begin
                        pc_nxt    = pc + 64'd4;
                        state_nxt = S_REQ;
                    end
                end
            end

            S_HALT: begin
                if (redirect) begin
                    err_nxt   = 1'b0;
                    pc_nxt    = redirect_pc;
                    state_nxt = S_REQ;
                end
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: a cycle-stepped bus responder feeds a scoreboard of expected
// request addresses and expected decode deliveries.
module tb_ifu_fetch;

    localparam logic [63:0] PC_RESET  = 64'h0000_0000_8000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect;
    logic [63:0] redirect_pc;
    logic        stall;
    logic        ibus_req;
    logic [63:0] ibus_addr;
    logic        ibus_ready;
    logic        ibus_rvalid;
    logic [31:0] ibus_rdata;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        idu_valid;
    logic        fetch_err;

    typedef struct packed {
        logic [31:0] word;
        logic [63:0] pc;
        logic        err;
    } deliv_t;

    deliv_t      exp_q[$];
    logic [63:0] addr_q[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          hs_cyc = 0;
    int          rsp_delay = 1;
    int          out_cnt = 0;
    logic        out_busy = 1'b0;
    logic        drop_rsp = 1'b0;
    logic        hs_seen = 1'b0;
    logic        vld_seen = 1'b0;
    logic [63:0] out_addr = 64'd0;

    ifu_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .ibus_req    (ibus_req),
        .ibus_addr   (ibus_addr),
        .ibus_ready  (ibus_ready),
        .ibus_rvalid (ibus_rvalid),
        .ibus_rdata  (ibus_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .idu_valid   (idu_valid),
        .fetch_err   (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h0000_0000_8000_0000) mem_word = 32'h0050_0093;
        else mem_word = {a[31:2], 2'b11} ^ 32'h0F0F_0000;
    endfunction

    // One clock: sample handshake before the edge, then update the bus model and
    // check deliveries 1 time unit after the edge.
    task automatic tick();
        logic        hs;
        logic        rst_s;
        logic [63:0] a;
        deliv_t      e;
        hs    = ibus_req && ibus_ready;
        a     = ibus_addr;
        rst_s = rst;
        @(posedge clk);
        #1;
        cyc++;
        redirect    = 1'b0;
        ibus_rvalid = 1'b0;
        hs_seen     = hs && !rst_s;
        vld_seen    = idu_valid;
        if (rst_s) begin
            out_busy = 1'b0;
            drop_rsp = 1'b0;
            addr_q.delete();
            exp_q.delete();
        end else begin
            if (hs) begin
                hs_cyc = cyc;
                if (addr_q.size() == 0) begin
                    chk("req_unexpected", 64'(hs), 64'd0);
                    out_addr = a;
                end else begin
                    out_addr = addr_q.pop_front();
                    chk("req_addr", a, out_addr);
                end
                out_busy = 1'b1;
                out_cnt  = rsp_delay;
            end
            if (out_busy) begin
                if (out_cnt <= 1) begin
                    ibus_rvalid = 1'b1;
                    ibus_rdata  = mem_word(out_addr);
                    out_busy    = 1'b0;
                    if (drop_rsp) begin
                        drop_rsp = 1'b0;
                    end else begin
                        e.word = mem_word(out_addr);
                        e.pc   = out_addr;
                        e.err  = 1'b0;
                        exp_q.push_back(e);
                    end
                end else begin
                    out_cnt--;
                end
            end
            if (idu_valid) begin
                if (exp_q.size() == 0) begin
                    chk("vld_unexpected", 64'(idu_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("dlv_instr", 64'(instr), 64'(e.word));
                    chk("dlv_pc", instr_pc, e.pc);
                    chk("dlv_err", 64'(fetch_err), 64'(e.err));
                end
            end
            if (fetch_err && !idu_valid) chk("ferr_stray", 64'(fetch_err), 64'd0);
        end
    endtask

    task automatic wait_hs(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!hs_seen && n < 20);
        chk(tag, 64'(hs_seen), 64'd1);
    endtask

    task automatic wait_vld(input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!vld_seen && n < 20);
        chk(tag, 64'(vld_seen), 64'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout got=%0d exp=finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        deliv_t e;
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 64'd0;
        stall       = 1'b0;
        ibus_ready  = 1'b0;
        ibus_rvalid = 1'b0;
        ibus_rdata  = 32'd0;
        tick();
        tick();
        chk("rst_req", 64'(ibus_req), 64'd0);
        chk("rst_vld", 64'(idu_valid), 64'd0);
        chk("rst_ferr", 64'(fetch_err), 64'd0);
        chk("rst_instr", 64'(instr), 64'(NOP_INSTR));
        chk("rst_instr_pc", instr_pc, PC_RESET);
        chk("rst_addr", ibus_addr, PC_RESET);

        // Basic fetch from reset
        ibus_ready = 1'b1;
        rsp_delay  = 1;
        addr_q.push_back(64'h8000_0000);
        addr_q.push_back(64'h8000_0004);
        rst = 1'b0;
        wait_vld("t1_vld");
        chk("t1_latency", 64'(cyc - hs_cyc), 64'd2);

        // Stall held for three cycles in DELIVER
        stall = 1'b1;
        addr_q.push_back(64'h8000_0008);
        wait_hs("t2_hs");
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_stall_vld", 64'(idu_valid), 64'd0);
            chk("t2_hold", 64'(instr), 64'(mem_word(64'h8000_0004)));
        end
        stall     = 1'b0;
        rsp_delay = 2;
        tick();
        chk("t2_release_vld", 64'(idu_valid), 64'd1);
        tick();
        chk("t2_single_pulse", 64'(idu_valid), 64'd0);
        chk("t3_hs", 64'(hs_seen), 64'd1);

        // Redirect while waiting for the response
        redirect    = 1'b1;
        redirect_pc = 64'h8000_0100;
        drop_rsp    = 1'b1;
        addr_q.push_back(64'h8000_0100);
        tick();
        wait_hs("t3_redir_hs");
        ibus_ready = 1'b0;
        addr_q.push_back(64'h8000_0104);
        wait_vld("t3_vld");

        // Redirects while the request is held off; the later target wins
        redirect    = 1'b1;
        redirect_pc = 64'h8000_0280;
        drop_rsp    = 1'b1;
        rsp_delay   = 1;
        tick();
        chk("t4_addr_hold0", ibus_addr, 64'h8000_0104);
        chk("t4_req_hold0", 64'(ibus_req), 64'd1);
        redirect    = 1'b1;
        redirect_pc = 64'h8000_0300;
        tick();
        chk("t4_addr_hold1", ibus_addr, 64'h8000_0104);
        addr_q.push_back(64'h8000_0300);
        ibus_ready = 1'b1;
        wait_hs("t4_hs");

        // Redirect together with stall in DELIVER, aligned target
        stall    = 1'b1;
        drop_rsp = 1'b1;
        wait_hs("t6_hs");
        tick();
        tick();
        chk("t6_stall_vld", 64'(idu_valid), 64'd0);
        addr_q.push_back(64'h8000_0400);
        redirect    = 1'b1;
        redirect_pc = 64'h8000_0400;
        tick();
        chk("t6_redir_vld", 64'(idu_valid), 64'd0);

        // Same again, this time to a misaligned target
        drop_rsp = 1'b1;
        wait_hs("t5_hs");
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 64'h8000_0102;
        tick();
        chk("t5_redir_vld", 64'(idu_valid), 64'd0);
        chk("t5_no_req0", 64'(ibus_req), 64'd0);
        stall  = 1'b0;
        e.word = NOP_INSTR;
        e.pc   = 64'h8000_0102;
        e.err  = 1'b1;
        exp_q.push_back(e);
        tick();
        chk("t5_no_req1", 64'(ibus_req), 64'd0);
        tick();
        chk("t5_vld", 64'(idu_valid), 64'd1);
        chk("t5_ferr", 64'(fetch_err), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_halt_req", 64'(ibus_req), 64'd0);
            chk("t5_halt_vld", 64'(idu_valid), 64'd0);
        end
        addr_q.push_back(64'h8000_0200);
        rsp_delay   = 3;
        redirect    = 1'b1;
        redirect_pc = 64'h8000_0200;
        wait_hs("t5_resume_hs");

        // Reset with a fetch in flight
        rst = 1'b1;
        tick();
        chk("rw_req", 64'(ibus_req), 64'd0);
        chk("rw_vld", 64'(idu_valid), 64'd0);
        chk("rw_ferr", 64'(fetch_err), 64'd0);
        chk("rw_instr", 64'(instr), 64'(NOP_INSTR));
        chk("rw_instr_pc", instr_pc, PC_RESET);
        chk("rw_addr", ibus_addr, PC_RESET);
        rst       = 1'b0;
        rsp_delay = 1;
        addr_q.push_back(PC_RESET);
        wait_vld("rw_restart_vld");
        chk("end_exp_empty", 64'(exp_q.size()), 64'd0);
        chk("end_addr_empty", 64'(addr_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
